// File: rtl/window_sum_pkg.sv
// Shared mode encodings, default widths and the saturating-add helper for window_sum_proc.
package window_sum_pkg;

   localparam logic MODE_WINDOW = 1'b0;
   localparam logic MODE_CUMUL  = 1'b1;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned DEPTH_DEF  = 8;
   localparam int unsigned SUM_W_DEF  = DATA_W_DEF + $clog2(DEPTH_DEF);
   localparam int unsigned CNT_W_DEF  = $clog2(DEPTH_DEF + 1);

   typedef struct packed {
      logic        hit;    // result was clamped to max
      logic [31:0] value;
   } sat_res_t;

   // min(a + b, max); widths up to 32 bits, computed with one guard bit.
   function automatic sat_res_t sat_add(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] max);
      sat_res_t    res;
      logic [32:0] wide;
      wide = {1'b0, a} + {1'b0, b};
      if (wide > {1'b0, max}) begin
         res.hit   = 1'b1;
         res.value = max;
      end else begin
         res.hit   = 1'b0;
         res.value = wide[31:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/sample_ring.sv
// Circular sample store: write pointer, fill count and the oldest (next-to-evict) entry.
module sample_ring #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              push,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] oldest,
   output logic              full,
   output logic [CNT_W-1:0]  count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [CNT_W-1:0]  count_q;

   // Storage is not reset; entries beyond count are never used.
   always_ff @(posedge clk) begin
      if (push && !clear) begin
         mem[wr_ptr_q] <= data_in;
      end
   end

   // Pointer wraps naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (clear) begin
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else if (push) begin
         wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (count_q != CNT_W'(DEPTH)) begin
            count_q <= count_q + CNT_W'(1);
         end
      end
   end

   // Once full, the slot about to be overwritten holds the oldest sample.
   assign oldest = mem[wr_ptr_q];
   assign full   = (count_q == CNT_W'(DEPTH));
   assign count  = count_q;

endmodule

// File: rtl/window_sum_proc.sv
// Streaming sliding-window / saturating cumulative sum with valid/ready on both sides.
module window_sum_proc
   import window_sum_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF,
   parameter int unsigned SUM_W  = DATA_W + $clog2(DEPTH),
   parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SUM_W-1:0]  sum_out,
   output logic [CNT_W-1:0]  count_out,
   output logic              sat_out
);

   localparam logic [SUM_W-1:0] SUM_MAX = '1;

   logic              accept;
   logic              flush;
   logic [DATA_W-1:0] oldest;
   logic              full;
   logic              mode_q;
   logic [SUM_W-1:0]  sum_q;
   logic [SUM_W-1:0]  sum_d;
   logic              sat_q;
   logic              sat_hit;
   logic              out_valid_q;
   sat_res_t          cum;

   assign flush    = rst || clear;
   assign in_ready = !clear && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready && !rst;

   sample_ring #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
   ) u_ring (
      .clk     (clk),
      .clear   (flush),
      .push    (accept),
      .data_in (data_in),
      .oldest  (oldest),
      .full    (full),
      .count   (count_out)
   );

   // Next sum: exact window arithmetic, or clamped cumulative add.
   always_comb begin
      cum     = sat_add(32'(sum_q), 32'(data_in), 32'(SUM_MAX));
      sum_d   = sum_q;
      sat_hit = 1'b0;
      if (mode_q == MODE_CUMUL) begin
         sum_d   = SUM_W'(cum.value);
         sat_hit = cum.hit;
      end else begin
         sum_d = sum_q + SUM_W'(data_in) - (full ? SUM_W'(oldest) : '0);
      end
   end

   // Mode latch, sum, sticky saturation and output valid stage.
   always_ff @(posedge clk) begin
      if (flush) begin
         mode_q      <= mode;
         sum_q       <= '0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (accept) begin
         sum_q       <= sum_d;
         sat_q       <= sat_q || sat_hit;
         out_valid_q <= 1'b1;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign sum_out   = sum_q;
   assign sat_out   = sat_q;
   assign out_valid = out_valid_q;

endmodule
